// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with generic width/depth, fill count,
// programmable almost-full/almost-empty flags and sticky overflow/underflow.
// Keeps the chip-select plus enable handshake of the older fixed-size FIFO.
//
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads
// (data_out shows the head word combinationally, zero read latency).
// Without it, data_out is registered and valid one cycle after a read.
//
// Parameter legality: ADDR_WIDTH >= 1, AF_MARGIN < DEPTH, AE_MARGIN < DEPTH.
module sync_fifo_param #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int AF_MARGIN  = 2,
   parameter int AE_MARGIN  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_cs,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_cs,
   input  logic                  rd_en,
   input  logic                  clr_err,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_empty,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_LEVEL  = (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);
   localparam logic [ADDR_WIDTH:0] AE_LEVEL  = (ADDR_WIDTH+1)'(AE_MARGIN);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic                  wr_req;
   logic                  rd_req;
   logic                  wr_acc;
   logic                  rd_acc;

   // Request decode; acceptance uses the flags from the registered (pre-edge) count,
   // so a write while full is refused even if a read is accepted on the same edge.
   always_comb begin
      wr_req = wr_cs & wr_en;
      rd_req = rd_cs & rd_en;
      wr_acc = wr_req & ~full;
      rd_acc = rd_req & ~empty;
   end

   // Status flags are pure decodes of the registered count.
   always_comb begin
      empty        = (count == '0);
      full         = (count == DEPTH_CNT);
      almost_empty = (count <= AE_LEVEL);
      almost_full  = (count >= AF_LEVEL);
   end

   // Storage array; deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // Pointers and occupancy; a simultaneous accepted read and write leaves count alone.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky error flags; a new error on the same edge as clr_err wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_req && full) begin
            overflow <= 1'b1;
         end else if (clr_err) begin
            overflow <= 1'b0;
         end
         if (rd_req && empty) begin
            underflow <= 1'b1;
         end else if (clr_err) begin
            underflow <= 1'b0;
         end
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Show-ahead: the head word is presented whenever the FIFO is not empty.
   always_comb begin
      data_out = mem[rd_ptr];
   end
`else
   // Registered read: data is valid the cycle after an accepted read, held otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out <= '0;
      end else if (rd_acc) begin
         data_out <= mem[rd_ptr];
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param (default parameters). A queue-based model holds
// the expected contents; flags, count, errors and read data are derived from
// the queue occupancy and the request rules.
module tb_sync_fifo_param;

   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk;
   logic          rst;
   logic          wr_cs;
   logic          wr_en;
   logic [DW-1:0] data_in;
   logic          rd_cs;
   logic          rd_en;
   logic          clr_err;
   logic [DW-1:0] data_out;
   logic          empty;
   logic          full;
   logic          almost_empty;
   logic          almost_full;
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;

   int n_chk  = 0;
   int n_pass = 0;

   logic [DW-1:0] q[$];
   logic          m_ovf;
   logic          m_unf;
   logic [DW-1:0] m_out;

   sync_fifo_param #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .AF_MARGIN (2),
      .AE_MARGIN (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_cs       (wr_cs),
      .wr_en       (wr_en),
      .data_in     (data_in),
      .rd_cs       (rd_cs),
      .rd_en       (rd_en),
      .clr_err     (clr_err),
      .data_out    (data_out),
      .empty       (empty),
      .full        (full),
      .almost_empty(almost_empty),
      .almost_full (almost_full),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic check_state(input string tag);
      chk({tag, ":count"}, 32'(count), 32'(q.size()));
      chk({tag, ":empty"}, 32'(empty), 32'(q.size() == 0));
      chk({tag, ":full"}, 32'(full), 32'(q.size() == DEPTH));
      chk({tag, ":almost_empty"}, 32'(almost_empty), 32'(q.size() <= 2));
      chk({tag, ":almost_full"}, 32'(almost_full), 32'(q.size() >= DEPTH - 2));
      chk({tag, ":overflow"}, 32'(overflow), 32'(m_ovf));
      chk({tag, ":underflow"}, 32'(underflow), 32'(m_unf));
`ifndef SYNC_FIFO_FWFT_EN
      chk({tag, ":data_out"}, 32'(data_out), 32'(m_out));
`endif
   endtask

   // One clock cycle: drive, advance the model with pre-edge occupancy, check after the edge.
   task automatic cycle(input string tag, input logic wc, input logic we, input logic [DW-1:0] d,
                        input logic rc, input logic re, input logic ce);
      logic was_full;
      logic was_empty;
      logic wreq;
      logic rreq;
      wr_cs   = wc;
      wr_en   = we;
      data_in = d;
      rd_cs   = rc;
      rd_en   = re;
      clr_err = ce;
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      wreq = wc & we;
      rreq = rc & re;
`ifdef SYNC_FIFO_FWFT_EN
      #1;
      if (!was_empty) chk({tag, ":fwft_head"}, 32'(data_out), 32'(q[0]));
`endif
      if (rreq && !was_empty) m_out = q.pop_front();
      if (wreq && !was_full) q.push_back(d);
      if (wreq && was_full) m_ovf = 1'b1;
      else if (ce) m_ovf = 1'b0;
      if (rreq && was_empty) m_unf = 1'b1;
      else if (ce) m_unf = 1'b0;
      @(posedge clk);
      #1;
      wr_cs = 1'b0; wr_en = 1'b0; rd_cs = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
      check_state(tag);
   endtask

   // Assert reset between clock edges and check the immediate (asynchronous) effect.
   task automatic mid_reset(input string tag);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_out = '0;
      chk({tag, ":count"}, 32'(count), 32'd0);
      chk({tag, ":empty"}, 32'(empty), 32'd1);
      chk({tag, ":overflow"}, 32'(overflow), 32'd0);
      chk({tag, ":underflow"}, 32'(underflow), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
      chk({tag, ":data_out"}, 32'(data_out), 32'd0);
`endif
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_state({tag, ":post"});
   endtask

   initial begin
      rst = 1'b0;
      wr_cs = 1'b0; wr_en = 1'b0; rd_cs = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
      data_in = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_out = '0;
      #12;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_state("reset");

      // Fill 1..16: flag thresholds are crossed along the way.
      for (int i = 1; i <= 16; i++) cycle("fill", 1, 1, 16'(i), 0, 0, 0);

      // Write while full is refused and sets overflow.
      cycle("overflow", 1, 1, 16'd17, 0, 0, 0);

      // Drain: data 1..16 in order, then an underflowing read holds data_out.
      for (int i = 1; i <= 16; i++) cycle("drain", 0, 0, '0, 1, 1, 0);
      cycle("underflow", 0, 0, '0, 1, 1, 0);
      cycle("clr_err", 0, 0, '0, 0, 0, 1);

      // Chip select without enable (and vice versa) is not a request.
      cycle("cs_only", 1, 0, 16'h1234, 1, 0, 0);
      cycle("en_only", 0, 1, 16'h1234, 0, 1, 0);

      // Simultaneous access at steady occupancy; pointers wrap.
      for (int i = 0; i < 5; i++) cycle("preload", 1, 1, 16'(100 + i), 0, 0, 0);
      for (int i = 0; i < 20; i++) cycle("simul", 1, 1, 16'(200 + i), 1, 1, 0);
      for (int i = 0; i < 11; i++) cycle("topup", 1, 1, 16'(300 + i), 0, 0, 0);
      cycle("simul_full", 1, 1, 16'hdead, 1, 1, 0);
      cycle("simul_full_clr", 0, 0, '0, 0, 0, 1);

      // Error set and clear on the same edge: set wins.
      cycle("refill", 1, 1, 16'h0aaa, 0, 0, 0);
      cycle("set_wins", 1, 1, 16'h0bbb, 0, 0, 1);
      cycle("clr", 0, 0, '0, 0, 0, 1);

      // Asynchronous reset with 7 words inside.
      mid_reset("pre_rst_drain");
      for (int i = 0; i < 7; i++) cycle("load7", 1, 1, 16'(400 + i), 0, 0, 0);
      mid_reset("mid_rst");
      cycle("after_rst_wr", 1, 1, 16'h5a5a, 0, 0, 0);
      cycle("after_rst_rd", 0, 0, '0, 1, 1, 0);

`ifdef SYNC_FIFO_FWFT_EN
      cycle("fwft_wr", 1, 1, 16'ha5a5, 0, 0, 0);
      chk("fwft_show", 32'(data_out), 32'h0000a5a5);
      cycle("fwft_rd", 0, 0, '0, 1, 1, 0);
`endif

      // Randomized traffic with an occasional error clear.
      for (int i = 0; i < 600; i++) begin
         logic [3:0] r;
         r = 4'($urandom);
         cycle("rand", r[0] | r[1], r[0] | r[2], 16'($urandom), r[3] | r[1], r[3] | r[2],
               ($urandom_range(0, 15) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO. Successor to the fixed 16x16 sync FIFO.
- Width and depth are generic. Adds a fill count, programmable almost-full and almost-empty flags, sticky overflow/underflow error flags, and a defined simultaneous read/write rule.
- Sits between producer and consumer logic in one clock domain. Keeps the chip-select plus enable handshake used by the existing FIFO.

Parameters:
DATA_WIDTH, 16, word width in bits
ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH entries
AF_MARGIN, 2, almost_full asserts when count >= DEPTH-AF_MARGIN
AE_MARGIN, 2, almost_empty asserts when count <= AE_MARGIN

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
wr_cs  input  1  write chip select
wr_en  input  1  write enable
data_in  input  DATA_WIDTH  write data
rd_cs  input  1  read chip select
rd_en  input  1  read enable
clr_err  input  1  synchronous clear of overflow/underflow
data_out  output  DATA_WIDTH  read data
empty  output  1  count == 0
full  output  1  count == DEPTH
almost_empty  output  1  count <= AE_MARGIN
almost_full  output  1  count >= DEPTH-AF_MARGIN
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rst low, async assert, sync release) sets:
  - wr_ptr, rd_ptr, count = 0; data_out = 0; overflow = underflow = 0.
  - So empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - Memory contents are not reset.
- Requests:
  - wr_req = wr_cs & wr_en; rd_req = rd_cs & rd_en.
  - Write accepted (wr_acc) iff wr_req & !full. Read accepted (rd_acc) iff rd_req & !empty.
  - Full/empty are evaluated on pre-edge state. A write when full is refused even if a read is accepted in the same cycle.
- Write: mem[wr_ptr] <= data_in; wr_ptr increments, wrapping DEPTH-1 -> 0 (natural ADDR_WIDTH rollover).
- Read, standard mode: data_out <= mem[rd_ptr] on the accepting edge, so data is valid 1 cycle after rd_acc. rd_ptr increments with wrap. data_out holds its last value when there is no rd_acc.
- count update:
  - +1 on wr_acc only; -1 on rd_acc only.
  - Unchanged when both are accepted, or when neither is.
  - Never leaves 0..DEPTH.
- Flags: full, empty, almost_full and almost_empty are combinational decodes of registered count. Glitch-free relative to clk; they reflect the new count the cycle after the edge.
- Errors:
  - overflow <= 1 on any edge with wr_req & full.
  - underflow <= 1 on any edge with rd_req & empty.
  - Both held until clr_err = 1 at an edge or reset. If set and clear occur in the same cycle, set wins.
  - A refused operation changes no pointer, count or data.
- Reset mid-operation: the in-flight access is discarded; the FIFO is empty immediately.
- Parameter legality: AF_MARGIN < DEPTH, AE_MARGIN < DEPTH, ADDR_WIDTH >= 1.

Optional Feature:
SYNC_FIFO_FWFT_EN
- Defined (first-word-fall-through):
  - data_out continuously presents mem[rd_ptr] (combinational show-ahead). It is valid whenever empty = 0; rd_acc pops the word and advances rd_ptr.
  - Read latency is 0. The data_out reset value is don't-care while empty.
- Undefined: standard registered read as described in Behaviour.
- Flags, count and errors are identical in both modes.

Test Plan:
- Reset and fill: DW=16, AW=4, default margins; write 1..16 on consecutive cycles.
  - count goes 1..16.
  - almost_full rises when count = 14.
  - full rises when count = 16.
  - almost_empty falls when count = 3.
- Overflow: with the FIFO full, write 17 -> refused; count stays 16; overflow = 1; the later read sequence contains no 17.
- Drain and underflow: read 16 times -> data_out = 1..16, one cycle after each read.
  - empty = 1 after the last read.
  - A 17th read sets underflow = 1 and data_out holds 16.
  - clr_err clears both error flags.
- Simultaneous access: preload 5 words; hold wr_req and rd_req for 20 cycles.
  - count stays 5 throughout.
  - Pointers wrap past 15 -> 0 and data stays in order.
  - At full, a simultaneous read and write pops one word and refuses the write, so count becomes 15.
- Async reset mid-stream: with count = 7, drive rst low between clock edges.
  - Without waiting for an edge: count = 0, empty = 1, data_out = 0.
  - After release, the next write/read returns the new data.
- FWFT (macro defined): write 0xA5A5 into an empty FIFO -> data_out = 0xA5A5 the cycle after the write with empty = 0; a read pops it with 0-cycle latency and empty returns to 1.
